user_input_check: RTL and testbench
===================================

// Module: user_input_check
// PURPOSE
//  User-entry stage of the memory game datapath, enabled by the controller's E2 (Play_User).
//  Reads player button presses and compares each against the stored sequence.
//  Returns end_User, end_time and match to the controller, which it reads in Check/Result.
// PARAMETERS
//  ADDR_W   4           sequence address width; max round = 2**ADDR_W-1
//  TIMEOUT  250000000   idle cycles allowed per entry (5 s @ 50 MHz), >= 2
//  DEB_CYC  500000      stable cycles required per key edge (only with USER_DEBOUNCE_EN)
// PORTS
//  CLOCK     in   1       system clock, all logic on posedge
//  reset     in   1       asynchronous, active-low; 0 forces reset state immediately
//  R2        in   1       synchronous round clear from controller, active-high
//  E2        in   1       enable user phase, level
//  KEY       in   4       raw push buttons, active-high, asynchronous to CLOCK
//  round     in   ADDR_W  current round; player must enter round+1 symbols
//  seq_data  in   2       expected symbol at seq_addr, combinational read (same cycle)
//  seq_addr  out  ADDR_W  index of symbol currently expected
//  user_code out  2       encoded last accepted key (KEY[i] -> i)
//  end_User  out  1       level: entry finished (complete or first mismatch)
//  end_time  out  1       level: per-entry timeout expired
//  match     out  1       level: 1 = all round+1 symbols correct; valid when end_User=1
// BEHAVIOUR
//  Reset (reset=0): state IDLE; seq_addr=0, user_code=0, end_User=0, end_time=0, match=0,
//   timer=0, synchronizers=0. All outputs registered.
//  Priority per edge: reset > R2 > FSM. R2=1: same values as reset, state IDLE, in any state.
//  KEY passes a 2-flop synchronizer -> ks. A press event is a cycle where ks_prev==0 and ks
//   is exactly one-hot. Multi-bit ks is ignored: no event, and the timer keeps counting.
//  FSM:
//   IDLE: E2=1 -> WAIT_PRESS, timer=0, seq_addr=0.
//   WAIT_PRESS: on a press event, latch user_code.
//    - code!=seq_data -> DONE, end_User=1, match=0.
//    - code==seq_data and seq_addr==round -> DONE, end_User=1, match=1.
//    - code==seq_data otherwise -> WAIT_RELEASE, seq_addr+1, timer=0.
//   WAIT_RELEASE: ks==0 -> WAIT_PRESS. No press events are accepted here.
//   Timer: counts in WAIT_PRESS and WAIT_RELEASE. Reaching TIMEOUT-1 -> TOUT,
//    end_time=1, match=0. A press event in that same cycle wins over the timeout.
//   DONE/TOUT: terminal; hold all outputs regardless of E2 or KEY until R2 or reset.
//  E2 dropping in WAIT_*: FSM freezes, timer holds, and presses are ignored. It resumes when E2 returns.
//  end_User and end_time are never both 1.
//  Latency: end_User rises on the 3rd CLOCK edge after a raw KEY rise.
//   This is 2 synchronizer edges plus 1 FSM edge.
//  seq_addr never exceeds round. The timer is ceil(log2(TIMEOUT)) bits and never wraps.
// CONFIGURATION
//  USER_DEBOUNCE_EN defined: each KEY bit must hold a new level for DEB_CYC consecutive
//   cycles after sync before ks updates. This adds DEB_CYC cycles to every latency.
//   Bounces shorter than DEB_CYC produce no event.
//  Not defined: ks = synchronizer output directly, and DEB_CYC is unused.
// TESTING (TIMEOUT=20, DEB_CYC=4 for sim)
//  1. reset=0 mid-WAIT_RELEASE with seq_addr=2 -> all outputs 0 immediately, no clock needed.
//  2. round=2, seq={1,3,0}; press KEY=0010,1000,0001 with releases
//     -> end_User=1, match=1, seq_addr=2, user_code=0.
//  3. round=2, seq={1,3,0}; press 0010 then 0100 -> end_User=1, match=0, user_code=2, seq_addr=1.
//  4. E2=1, no press for 20 cycles -> end_time=1, end_User=0, match=0. Then R2=1 -> all 0, IDLE.
//  5. KEY=0011 held, then 0000 -> no event, seq_addr=0. Press lands on timer==19 -> accepted, no timeout.
//  6. USER_DEBOUNCE_EN: 2-cycle glitch on KEY[1] -> ignored. 10-cycle press -> accepted.

Source files
------------

// File: rtl/user_input_check.sv
// User-entry stage of the memory game: synchronises KEY presses and compares each one
// against the stored sequence. Optional debounce is enabled with `define USER_DEBOUNCE_EN.
module user_input_check #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 250000000,
    parameter int unsigned DEB_CYC = 500000
) (
    input  logic              CLOCK,
    input  logic              reset,
    input  logic              R2,
    input  logic              E2,
    input  logic [3:0]        KEY,
    input  logic [ADDR_W-1:0] round,
    input  logic [1:0]        seq_data,
    output logic [ADDR_W-1:0] seq_addr,
    output logic [1:0]        user_code,
    output logic              end_User,
    output logic              end_time,
    output logic              match
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitPress,
        StWaitRelease,
        StDone,
        StTout
    } state_e;

    state_e            state_q;
    logic [TW-1:0]     timer_q;
    logic [ADDR_W-1:0] seq_addr_q;
    logic [1:0]        user_code_q;
    logic              end_user_q;
    logic              end_time_q;
    logic              match_q;

    logic [3:0] key_meta_q;
    logic [3:0] key_sync_q;
    logic [3:0] ks_prev_q;
    logic [3:0] ks;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            key_meta_q <= '0;
            key_sync_q <= '0;
            ks_prev_q  <= '0;
        end else if (R2) begin
            key_meta_q <= '0;
            key_sync_q <= '0;
            ks_prev_q  <= '0;
        end else begin
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
            ks_prev_q  <= ks;
        end
    end

`ifdef USER_DEBOUNCE_EN
    localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [3:0][DW-1:0] deb_cnt_q;
    logic [3:0]         ks_q;

    // A bit only takes its new level after DEB_CYC consecutive cycles of disagreement.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            deb_cnt_q <= '0;
            ks_q      <= '0;
        end else if (R2) begin
            deb_cnt_q <= '0;
            ks_q      <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_sync_q[i] != ks_q[i]) begin
                    if (deb_cnt_q[i] == DW'(DEB_CYC - 1)) begin
                        ks_q[i]      <= key_sync_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign ks = ks_q;
`else
    assign ks = key_sync_q;
`endif

    logic       press;
    logic [1:0] press_code;

    always_comb begin
        press_code = '0;
        for (int i = 0; i < 4; i++) begin
            if (ks[i]) press_code = 2'(i);
        end
        // Only a clean one-hot edge out of all-released counts as a press.
        press = (ks_prev_q == '0) && (ks != '0) && ((ks & (ks - 4'd1)) == '0);
    end

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            seq_addr_q  <= '0;
            user_code_q <= '0;
            end_user_q  <= 1'b0;
            end_time_q  <= 1'b0;
            match_q     <= 1'b0;
        end else if (R2) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            seq_addr_q  <= '0;
            user_code_q <= '0;
            end_user_q  <= 1'b0;
            end_time_q  <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (E2) begin
                        state_q    <= StWaitPress;
                        timer_q    <= '0;
                        seq_addr_q <= '0;
                    end
                end
                StWaitPress: begin
                    if (E2) begin
                        if (press) begin
                            user_code_q <= press_code;
                            if (press_code != seq_data) begin
                                state_q    <= StDone;
                                end_user_q <= 1'b1;
                                match_q    <= 1'b0;
                            end else if (seq_addr_q == round) begin
                                state_q    <= StDone;
                                end_user_q <= 1'b1;
                                match_q    <= 1'b1;
                            end else begin
                                state_q    <= StWaitRelease;
                                seq_addr_q <= seq_addr_q + 1'b1;
                                timer_q    <= '0;
                            end
                        end else if (timer_q == TimerMax) begin
                            state_q    <= StTout;
                            end_time_q <= 1'b1;
                            match_q    <= 1'b0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end
                StWaitRelease: begin
                    if (E2) begin
                        if (timer_q == TimerMax) begin
                            state_q    <= StTout;
                            end_time_q <= 1'b1;
                            match_q    <= 1'b0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                            if (ks == '0) state_q <= StWaitPress;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign seq_addr  = seq_addr_q;
    assign user_code = user_code_q;
    assign end_User  = end_user_q;
    assign end_time  = end_time_q;
    assign match     = match_q;

endmodule

// File: tb/tb_user_input_check.sv
// Directed bench for user_input_check: table of full rounds plus hand-written
// timeout, reset, freeze and multi-key sequences.
module tb_user_input_check;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned DEB_CYC = 4;
`ifdef USER_DEBOUNCE_EN
    localparam int LAT = DEB_CYC;
`else
    localparam int LAT = 0;
`endif
    localparam int HOLD = 4;

    logic              CLOCK;
    logic              reset;
    logic              R2;
    logic              E2;
    logic [3:0]        KEY;
    logic [ADDR_W-1:0] round;
    logic [1:0]        seq_data;
    logic [ADDR_W-1:0] seq_addr;
    logic [1:0]        user_code;
    logic              end_User;
    logic              end_time;
    logic              match;

    logic [1:0] seq_mem [16];
    assign seq_data = seq_mem[seq_addr];

    user_input_check #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .DEB_CYC(DEB_CYC)
    ) dut (
        .CLOCK    (CLOCK),
        .reset    (reset),
        .R2       (R2),
        .E2       (E2),
        .KEY      (KEY),
        .round    (round),
        .seq_data (seq_data),
        .seq_addr (seq_addr),
        .user_code(user_code),
        .end_User (end_User),
        .end_time (end_time),
        .match    (match)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic clear_round();
        R2  = 1'b1;
        E2  = 1'b0;
        KEY = 4'b0000;
        cycles(1);
        R2 = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        KEY = k;
        cycles(HOLD + LAT);
        KEY = 4'b0000;
        cycles(HOLD + LAT);
    endtask

    task automatic set_seq(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
        seq_mem[0] = s0;
        seq_mem[1] = s1;
        seq_mem[2] = s2;
    endtask

    typedef struct {
        logic [3:0] rnd;
        logic [1:0] s0, s1, s2;
        int         n;
        logic [3:0] k0, k1, k2;
        logic       eu, m;
        logic [1:0] code;
        logic [3:0] addr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{4'd2, 2'd1, 2'd3, 2'd0, 3, 4'b0010, 4'b1000, 4'b0001, 1'b1, 1'b1, 2'd0, 4'd2};
        vecs[1] = '{4'd2, 2'd1, 2'd3, 2'd0, 2, 4'b0010, 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd2, 4'd1};
        vecs[2] = '{4'd0, 2'd2, 2'd0, 2'd0, 1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'd0};
        vecs[3] = '{4'd1, 2'd3, 2'd3, 2'd0, 2, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 4'd1};
        vecs[4] = '{4'd2, 2'd1, 2'd3, 2'd0, 1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'd0};
        vecs[5] = '{4'd1, 2'd0, 2'd2, 2'd0, 2, 4'b0001, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd1, 4'd1};

        for (int i = 0; i < 16; i++) seq_mem[i] = 2'd0;
        reset = 1'b0;
        R2    = 1'b0;
        E2    = 1'b0;
        KEY   = 4'b0000;
        round = '0;
        #1;
        check("rst_addr", 32'(seq_addr), 0);
        check("rst_code", 32'(user_code), 0);
        check("rst_end_user", 32'(end_User), 0);
        check("rst_end_time", 32'(end_time), 0);
        check("rst_match", 32'(match), 0);
        cycles(2);
        reset = 1'b1;
        cycles(1);

        for (int i = 0; i < 6; i++) begin
            clear_round();
            round = vecs[i].rnd;
            set_seq(vecs[i].s0, vecs[i].s1, vecs[i].s2);
            E2 = 1'b1;
            cycles(1);
            if (vecs[i].n > 0) press(vecs[i].k0);
            if (vecs[i].n > 1) press(vecs[i].k1);
            if (vecs[i].n > 2) press(vecs[i].k2);
            cycles(3);
            check($sformatf("v%0d_end_user", i), 32'(end_User), 32'(vecs[i].eu));
            check($sformatf("v%0d_end_time", i), 32'(end_time), 0);
            check($sformatf("v%0d_match", i), 32'(match), 32'(vecs[i].m));
            check($sformatf("v%0d_code", i), 32'(user_code), 32'(vecs[i].code));
            check($sformatf("v%0d_addr", i), 32'(seq_addr), 32'(vecs[i].addr));
            // Terminal state must ignore further presses.
            press(4'b0100);
            check($sformatf("v%0d_hold_code", i), 32'(user_code), 32'(vecs[i].code));
            check($sformatf("v%0d_hold_end", i), 32'(end_User), 32'(vecs[i].eu));
        end

        // Timeout: exactly TIMEOUT idle cycles in WAIT_PRESS after the IDLE edge.
        clear_round();
        round = 4'd2;
        set_seq(2'd1, 2'd3, 2'd0);
        E2 = 1'b1;
        cycles(20);
        check("tout_early", 32'(end_time), 0);
        cycles(1);
        check("tout_end_time", 32'(end_time), 1);
        check("tout_end_user", 32'(end_User), 0);
        check("tout_match", 32'(match), 0);
        R2 = 1'b1;
        E2 = 1'b0;
        cycles(1);
        R2 = 1'b0;
        check("r2_end_time", 32'(end_time), 0);
        check("r2_addr", 32'(seq_addr), 0);
        cycles(25);
        check("r2_idle_end_time", 32'(end_time), 0);

        // Multi-key chord ignored, then a press landing on the last timer cycle wins.
        clear_round();
        round = 4'd2;
        set_seq(2'd1, 2'd3, 2'd0);
        E2  = 1'b1;
        KEY = 4'b0011;
        cycles(6);
        KEY = 4'b0000;
        cycles(12 - LAT);
        check("chord_end_user", 32'(end_User), 0);
        check("chord_addr", 32'(seq_addr), 0);
        KEY = 4'b0010;
        cycles(3 + LAT);
        check("last_cyc_addr", 32'(seq_addr), 1);
        check("last_cyc_end_time", 32'(end_time), 0);
        check("last_cyc_code", 32'(user_code), 1);
        KEY = 4'b0000;
        cycles(4 + LAT);
        check("last_cyc_no_tout", 32'(end_time), 0);

        // E2 low freezes the FSM; presses during the freeze are dropped.
        clear_round();
        round = 4'd0;
        set_seq(2'd2, 2'd0, 2'd0);
        E2 = 1'b1;
        cycles(1);
        E2 = 1'b0;
        press(4'b0100);
        check("freeze_end_user", 32'(end_User), 0);
        check("freeze_code", 32'(user_code), 0);
        E2 = 1'b1;
        press(4'b0100);
        check("resume_end_user", 32'(end_User), 1);
        check("resume_match", 32'(match), 1);

        // Asynchronous reset while in WAIT_RELEASE at seq_addr=2.
        clear_round();
        round = 4'd2;
        set_seq(2'd1, 2'd3, 2'd0);
        E2 = 1'b1;
        cycles(1);
        press(4'b0010);
        KEY = 4'b1000;
        cycles(3 + LAT);
        check("pre_rst_addr", 32'(seq_addr), 2);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_addr", 32'(seq_addr), 0);
        check("async_rst_code", 32'(user_code), 0);
        check("async_rst_end_user", 32'(end_User), 0);
        check("async_rst_end_time", 32'(end_time), 0);
        check("async_rst_match", 32'(match), 0);
        KEY = 4'b0000;
        E2  = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(1);

`ifdef USER_DEBOUNCE_EN
        clear_round();
        round = 4'd0;
        set_seq(2'd1, 2'd0, 2'd0);
        E2 = 1'b1;
        cycles(1);
        KEY = 4'b0010;
        cycles(2);
        KEY = 4'b0000;
        cycles(6);
        check("glitch_end_user", 32'(end_User), 0);
        KEY = 4'b0010;
        cycles(10);
        KEY = 4'b0000;
        cycles(2);
        check("deb_end_user", 32'(end_User), 1);
        check("deb_match", 32'(match), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
